// File: rtl/rojobot_pkg.sv
// rojobot_pkg: shared defaults and FSM encoding for the robot pose synchronizer
package rojobot_pkg;
  localparam int SCALING_FACTOR_DEF = 6;
  localparam int SPRITE_COLS_DEF = 34;
  localparam int SPRITE_ROWS_DEF = 34;
  typedef enum logic [1:0] {IDLE, CALC, READY, COMMIT} state_t;
endpackage

// File: rtl/robot_pose_sync_if.sv
// robot_pose_sync_if: bot CPU pose input and committed pose/sprite outputs
interface robot_pose_sync_if;
  logic upd_sysregs;
  logic [7:0] LocX_in, LocY_in, BotInfo_in;
  logic signed [31:0] LocX_reg, LocY_reg;
  logic signed [31:0] robot_screen_left, robot_screen_right, robot_screen_top, robot_screen_bottom;
  logic [7:0] BotInfo_reg, drop_count;
  logic pose_valid, commit_pulse;
  modport master (
    output upd_sysregs, LocX_in, LocY_in, BotInfo_in,
    input LocX_reg, LocY_reg, BotInfo_reg, robot_screen_left, robot_screen_right,
    input robot_screen_top, robot_screen_bottom, pose_valid, commit_pulse, drop_count
  );
  modport slave (
    input upd_sysregs, LocX_in, LocY_in, BotInfo_in,
    output LocX_reg, LocY_reg, BotInfo_reg, robot_screen_left, robot_screen_right,
    output robot_screen_top, robot_screen_bottom, pose_valid, commit_pulse, drop_count
  );
endinterface

// File: rtl/seq_mul8.sv
// seq_mul8: 8-cycle shift-add multiply of an 8-bit operand by a constant
module seq_mul8 #(
  parameter int M = 6
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [7:0] a,
  output logic signed [31:0] p,
  output logic done
);
  logic [7:0] sh;
  logic [31:0] mk;
  logic [2:0] cnt;
  logic busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sh <= '0;
      mk <= '0;
      cnt <= '0;
      busy <= 1'b0;
      p <= '0;
      done <= 1'b0;
    end else if (start) begin
      sh <= a;
      mk <= 32'(M);
      cnt <= '0;
      busy <= 1'b1;
      p <= '0;
      done <= 1'b0;
    end else if (busy) begin
      p <= p + (sh[0] ? mk : 32'd0);
      sh <= sh >> 1;
      mk <= mk << 1;
      cnt <= cnt + 3'd1;
      busy <= cnt != 3'd7;
      done <= cnt == 3'd7;
    end
endmodule

// File: rtl/robot_pose_sync.sv
// robot_pose_sync: stages bot poses and commits pose plus sprite bounds on vblank
module robot_pose_sync
  import rojobot_pkg::*;
#(
  parameter int SCALING_FACTOR = SCALING_FACTOR_DEF,
  parameter int SPRITE_COLS = SPRITE_COLS_DEF,
  parameter int SPRITE_ROWS = SPRITE_ROWS_DEF
) (
  input logic clk,
  input logic reset,
  input logic vblank,
  robot_pose_sync_if.slave bus
);
  localparam int CX = (SPRITE_COLS - SCALING_FACTOR) / 2;
  localparam int CY = (SPRITE_ROWS - SCALING_FACTOR) / 2;
  state_t state;
  logic pend, vb_q, dx, dy, consume, vb_rise;
  logic [7:0] sx, sy, si, wx, wy, wi;
  logic [2:0] cnt;
  logic signed [31:0] px, py;
  assign consume = (state == IDLE) && pend;
  assign vb_rise = vblank && !vb_q;
  seq_mul8 #(.M(SCALING_FACTOR)) mul_x (.clk(clk), .reset(reset), .start(consume), .a(sx), .p(px), .done(dx));
  seq_mul8 #(.M(SCALING_FACTOR)) mul_y (.clk(clk), .reset(reset), .start(consume), .a(sy), .p(py), .done(dy));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= 1'b0;
      sx <= '0;
      sy <= '0;
      si <= '0;
      bus.drop_count <= '0;
    end else begin
      if (bus.upd_sysregs) begin
        sx <= bus.LocX_in;
        sy <= bus.LocY_in;
        si <= bus.BotInfo_in;
      end
      pend <= bus.upd_sysregs || (pend && !consume);
      if (bus.upd_sysregs && pend && !consume && bus.drop_count != 8'hff)
        bus.drop_count <= bus.drop_count + 8'd1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      vb_q <= 1'b0;
      wx <= '0;
      wy <= '0;
      wi <= '0;
      bus.LocX_reg <= '0;
      bus.LocY_reg <= '0;
      bus.BotInfo_reg <= '0;
      bus.robot_screen_left <= 32'(-CX);
      bus.robot_screen_right <= 32'(SCALING_FACTOR - 1 + CX);
      bus.robot_screen_top <= 32'(-CY);
      bus.robot_screen_bottom <= 32'(SCALING_FACTOR - 1 + CY);
      bus.pose_valid <= 1'b0;
      bus.commit_pulse <= 1'b0;
    end else begin
      vb_q <= vblank;
      bus.commit_pulse <= 1'b0;
      case (state)
        IDLE: if (pend) begin
          wx <= sx;
          wy <= sy;
          wi <= si;
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= READY;
        end
        READY: if (vb_rise && dx && dy) begin
          bus.LocX_reg <= {24'd0, wx};
          bus.LocY_reg <= {24'd0, wy};
          bus.BotInfo_reg <= wi;
          bus.robot_screen_left <= px - 32'(CX);
          bus.robot_screen_right <= px + 32'(SCALING_FACTOR - 1 + CX);
          bus.robot_screen_top <= py - 32'(CY);
          bus.robot_screen_bottom <= py + 32'(SCALING_FACTOR - 1 + CY);
          bus.commit_pulse <= 1'b1;
          bus.pose_valid <= 1'b1;
          state <= COMMIT;
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_robot_pose_sync.sv
// tb_robot_pose_sync: directed self-checking bench for robot_pose_sync
module tb_robot_pose_sync;
  logic clk = 1'b0, reset = 1'b0, vblank = 1'b0;
  int checks = 0, errors = 0, ncommit = 0;
  localparam logic [199:0] RST_O = {32'sd0, 32'sd0, -32'sd14, 32'sd19, -32'sd14, 32'sd19, 8'h00};
  robot_pose_sync_if bus ();
  robot_pose_sync dut (.clk(clk), .reset(reset), .vblank(vblank), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.commit_pulse === 1'b1) ncommit <= ncommit + 1;
  function automatic logic [199:0] outs();
    return {bus.LocX_reg, bus.LocY_reg, bus.robot_screen_left, bus.robot_screen_right,
            bus.robot_screen_top, bus.robot_screen_bottom, bus.BotInfo_reg};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [7:0] x, input logic [7:0] y, input logic [7:0] i);
    bus.upd_sysregs = 1'b1;
    bus.LocX_in = x;
    bus.LocY_in = y;
    bus.BotInfo_in = i;
    tick(1);
    bus.upd_sysregs = 1'b0;
  endtask
  task automatic wait_commit(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick(1);
      ok = bus.commit_pulse;
    end
  endtask
  task automatic test_reset();
    bus.upd_sysregs = 1'b0;
    bus.LocX_in = '0;
    bus.LocY_in = '0;
    bus.BotInfo_in = '0;
    reset = 1'b0;
    tick(3);
    checks++; if (outs() !== RST_O) begin errors++; $display("FAIL reset_outs: got %h want %h", outs(), RST_O); end
    checks++; if (bus.pose_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.pose_valid); end
    checks++; if (bus.commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.commit_pulse); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
    reset = 1'b1;
    tick(2);
  endtask
  task automatic test_latency();
    logic [199:0] e;
    e = {32'sd1, 32'sd2, -32'sd8, 32'sd25, -32'sd2, 32'sd31, 8'hA5};
    pulse(8'd1, 8'd2, 8'hA5);
    tick(9);
    vblank = 1'b1;
    checks++; if (bus.commit_pulse !== 1'b0) begin errors++; $display("FAIL lat_early_pulse: got %b want 0", bus.commit_pulse); end
    checks++; if (outs() !== RST_O) begin errors++; $display("FAIL lat_early_outs: got %h want %h", outs(), RST_O); end
    tick(1);
    checks++; if (bus.commit_pulse !== 1'b1) begin errors++; $display("FAIL lat_pulse: got %b want 1", bus.commit_pulse); end
    checks++; if (outs() !== e) begin errors++; $display("FAIL lat_outs: got %h want %h", outs(), e); end
    checks++; if (bus.pose_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", bus.pose_valid); end
    tick(1);
    checks++; if (bus.commit_pulse !== 1'b0) begin errors++; $display("FAIL lat_pulse_width: got %b want 0", bus.commit_pulse); end
    vblank = 1'b0;
    tick(3);
  endtask
  task automatic test_basic();
    logic [199:0] e, p;
    int c0;
    bit ok;
    e = {32'sd10, 32'sd20, 32'sd46, 32'sd79, 32'sd106, 32'sd139, 8'h32};
    p = outs();
    c0 = ncommit;
    pulse(8'd10, 8'd20, 8'h32);
    tick(19);
    checks++; if (outs() !== p) begin errors++; $display("FAIL basic_hold: got %h want %h", outs(), p); end
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_commit: got none want commit_pulse"); end
    checks++; if (outs() !== e) begin errors++; $display("FAIL basic_outs: got %h want %h", outs(), e); end
    tick(3);
    vblank = 1'b0;
    tick(15);
    checks++; if (ncommit - c0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", ncommit - c0); end
  endtask
  task automatic test_early_vblank();
    logic [199:0] e, p;
    int c0;
    bit ok;
    e = {32'sd3, 32'sd4, 32'sd4, 32'sd37, 32'sd10, 32'sd43, 8'h11};
    p = outs();
    c0 = ncommit;
    pulse(8'd3, 8'd4, 8'h11);
    tick(2);
    vblank = 1'b1;
    tick(2);
    vblank = 1'b0;
    tick(20);
    checks++; if (ncommit !== c0) begin errors++; $display("FAIL early_nocommit: got %0d want %0d", ncommit, c0); end
    checks++; if (outs() !== p) begin errors++; $display("FAIL early_hold: got %h want %h", outs(), p); end
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_commit: got none want commit_pulse"); end
    checks++; if (outs() !== e) begin errors++; $display("FAIL early_outs: got %h want %h", outs(), e); end
    vblank = 1'b0;
    tick(3);
  endtask
  task automatic test_back_to_back();
    logic [199:0] e1, e2;
    int c0;
    bit ok;
    e1 = {32'sd5, 32'sd5, 32'sd16, 32'sd49, 32'sd16, 32'sd49, 8'h05};
    e2 = {32'sd7, 32'sd7, 32'sd28, 32'sd61, 32'sd28, 32'sd61, 8'h07};
    c0 = ncommit;
    pulse(8'd5, 8'd5, 8'h05);
    tick(1);
    pulse(8'd6, 8'd6, 8'h06);
    pulse(8'd7, 8'd7, 8'h07);
    checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL b2b_drop: got %0d want 1", bus.drop_count); end
    tick(10);
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok || outs() !== e1) begin errors++; $display("FAIL b2b_first: got %h want %h", outs(), e1); end
    vblank = 1'b0;
    tick(15);
    checks++; if (ncommit - c0 !== 1) begin errors++; $display("FAIL b2b_one_per_frame: got %0d want 1", ncommit - c0); end
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok || outs() !== e2) begin errors++; $display("FAIL b2b_second: got %h want %h", outs(), e2); end
    vblank = 1'b0;
    tick(3);
  endtask
  task automatic test_coincide();
    logic [199:0] e1, e2;
    bit ok;
    e1 = {32'sd8, 32'sd8, 32'sd34, 32'sd67, 32'sd34, 32'sd67, 8'h08};
    e2 = {32'sd9, 32'sd9, 32'sd40, 32'sd73, 32'sd40, 32'sd73, 8'h09};
    pulse(8'd8, 8'd8, 8'h08);
    pulse(8'd9, 8'd9, 8'h09);
    tick(12);
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok || outs() !== e1) begin errors++; $display("FAIL coin_first: got %h want %h", outs(), e1); end
    vblank = 1'b0;
    tick(15);
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok || outs() !== e2) begin errors++; $display("FAIL coin_second: got %h want %h", outs(), e2); end
    checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL coin_drop: got %0d want 1", bus.drop_count); end
    vblank = 1'b0;
    tick(3);
  endtask
  task automatic test_extreme();
    logic [199:0] e;
    bit ok;
    e = {32'sd0, 32'sd255, -32'sd14, 32'sd19, 32'sd1516, 32'sd1549, 8'hFF};
    pulse(8'd0, 8'd255, 8'hFF);
    tick(12);
    vblank = 1'b1;
    wait_commit(5, ok);
    checks++; if (!ok || outs() !== e) begin errors++; $display("FAIL extreme_outs: got %h want %h", outs(), e); end
    vblank = 1'b0;
    tick(3);
  endtask
  task automatic test_reset_ready();
    int c0;
    pulse(8'd50, 8'd60, 8'h77);
    tick(12);
    reset = 1'b0;
    #1;
    checks++; if (outs() !== RST_O) begin errors++; $display("FAIL rstr_outs: got %h want %h", outs(), RST_O); end
    checks++; if (bus.pose_valid !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL rstr_flags: got valid %b drop %0d want 0 0", bus.pose_valid, bus.drop_count); end
    tick(2);
    reset = 1'b1;
    c0 = ncommit;
    for (int f = 0; f < 2; f++) begin
      tick(15);
      vblank = 1'b1;
      tick(3);
      vblank = 1'b0;
    end
    tick(3);
    checks++; if (ncommit !== c0) begin errors++; $display("FAIL rstr_nocommit: got %0d want %0d", ncommit, c0); end
  endtask
  task automatic test_saturate();
    int c0;
    c0 = ncommit;
    for (int i = 0; i < 300; i++) begin
      pulse(8'(i), 8'(i + 1), 8'(i + 2));
      if (i == 99) begin
        checks++; if (bus.drop_count !== 8'd98) begin errors++; $display("FAIL sat_mid: got %0d want 98", bus.drop_count); end
      end
    end
    tick(20);
    checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL sat_drop: got %0d want 255", bus.drop_count); end
    checks++; if (outs() !== RST_O) begin errors++; $display("FAIL sat_outs: got %h want %h", outs(), RST_O); end
    checks++; if (bus.pose_valid !== 1'b0 || ncommit !== c0) begin errors++; $display("FAIL sat_valid: got valid %b commits %0d want 0 %0d", bus.pose_valid, ncommit, c0); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_early_vblank();
    test_back_to_back();
    test_coincide();
    test_extreme();
    test_reset_ready();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
